ro_freq_counter: RTL



---
 rtl/ro_meas_pkg.sv | 18 +
 rtl/ro_sync_edge.sv | 26 ++
 rtl/ro_freq_counter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement blocks.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StGate,
    StDone
  } ro_state_e;

  localparam int unsigned AVG_WINDOWS = 4;

  // Gate counter width; GATE_CYCLES >= 2 keeps this at least 1.
  function automatic int unsigned gate_cnt_w(input int unsigned gate_cycles);
    return $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus rising-edge detector.
module ro_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_out = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Counts rising edges of the divided ring oscillator over a fixed gate window.
// Define RO_FREQ_AVG_EN to average four consecutive windows per measurement.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1024,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             valid
);

  localparam int unsigned GCW = gate_cnt_w(GATE_CYCLES);
`ifdef RO_FREQ_AVG_EN
  localparam int unsigned ACC_W = CNT_W + 2;
`else
  localparam int unsigned ACC_W = CNT_W;
`endif
  localparam logic [GCW-1:0] GateLast = GCW'(GATE_CYCLES - 1);

  ro_state_e        state_q, state_d;
  logic [GCW-1:0]   gate_q, gate_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ro_edge;
  logic             gate_last;
  logic             win_last;

  ro_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(ro_in),
    .edge_out(ro_edge)
  );

  assign gate_last = (gate_q == GateLast);

`ifdef RO_FREQ_AVG_EN
  logic [1:0] win_q, win_d;
  assign win_last = (win_q == 2'(AVG_WINDOWS - 1));
`else
  assign win_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gate_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef RO_FREQ_AVG_EN
      win_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
`ifdef RO_FREQ_AVG_EN
      win_q   <= win_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StArm;
      StArm:   state_d = StGate;
      StGate:  if (gate_last && win_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gate_d  = gate_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
`ifdef RO_FREQ_AVG_EN
    win_d   = win_q;
`endif
    if (state_q == StArm) begin
      gate_d = '0;
      acc_d  = '0;
      sat_d  = 1'b0;
`ifdef RO_FREQ_AVG_EN
      win_d  = '0;
`endif
    end else if (state_q == StGate) begin
      gate_d = gate_last ? '0 : gate_q + GCW'(1);
      // Saturate rather than wrap; an edge lost to saturation flags overflow.
      if (ro_edge) begin
        if (&acc_q) sat_d = 1'b1;
        else        acc_d = acc_q + ACC_W'(1);
      end
`ifdef RO_FREQ_AVG_EN
      if (gate_last) win_d = win_q + 2'd1;
`endif
      if (gate_last && win_last) begin
`ifdef RO_FREQ_AVG_EN
        count_d = acc_d[ACC_W-1:2];
`else
        count_d = acc_d;
`endif
        ovf_d = sat_d;
      end
    end
  end

  always_comb begin
    busy  = (state_q != StIdle);
    valid = (state_q == StDone);
    count = count_q;
    ovf   = ovf_q;
  end

endmodule
